// File: rtl/reg_writeback_queue_if.sv
// reg_writeback_queue_if
//   Bundles every non-clock/reset signal of the register write-back queue.
//   slave  : the queue itself (takes results, drives the register file write port,
//            the forwarding results, the pending scoreboard and the occupancy count)
//   master : the surrounding pipeline / testbench driving results, stall and read
//            addresses.
//   Signal groups:
//     mem_*                      memory-path result handshake
//     alu_*                      ALU result handshake
//     rf_stall                   hold the dequeue side
//     writeEn/writeAddr/writeData registered register-file write port
//     readAddr1/2, fwd_*         decode bypass lookup
//     pending, count             scoreboard and FIFO occupancy
interface reg_writeback_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              rf_stall;

  logic              writeEn;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  logic [ADDR_W-1:0] readAddr1;
  logic [ADDR_W-1:0] readAddr2;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;

  logic [(2**ADDR_W)-1:0] pending;
  logic [CW-1:0]          count;

  modport slave (
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  rf_stall,
    output writeEn, writeAddr, writeData,
    input  readAddr1, readAddr2,
    output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
    output pending, count
  );

  modport master (
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output rf_stall,
    input  writeEn, writeAddr, writeData,
    output readAddr1, readAddr2,
    input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
    input  pending, count
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   In-order write-back FIFO in front of the register file. Accepts up to two
//   results per cycle (memory path older than ALU path), drains one per cycle onto
//   the registered write port, and exposes a pending-register scoreboard plus
//   newest-value forwarding for two decode read addresses.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    reg_writeback_queue_if.slave (all handshake, write port, forwarding,
//            pending and count signals)
module reg_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  reset,
  reg_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2 ** ADDR_W;

  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic mem_ready, alu_ready;
  logic mem_acc, alu_acc, deq;

  // Readiness looks only at the registered count; a same-cycle dequeue earns no
  // credit, so an enqueue can never land on the slot being popped.
  assign mem_ready = (count_q <= DEPTH_M1);
  assign alu_ready = (count_q <= DEPTH_M2) || ((count_q == DEPTH_M1) && !bus.mem_valid);
  assign mem_acc   = bus.mem_valid && mem_ready;
  assign alu_acc   = bus.alu_valid && alu_ready;
  assign deq       = (count_q != '0) && !bus.rf_stall;

  // Next-state for storage, pointers, count and the output stage.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise an
    // unassigned path in always_comb infers a latch.
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
    write_en_d   = deq;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    // The memory result is older, so it takes the first free slot.
    if (mem_acc) mem_d[wr_ptr_q] = '{addr: bus.mem_addr, data: bus.mem_data};
    if (alu_acc) mem_d[wr_ptr_q + PW'(mem_acc)] = '{addr: bus.alu_addr, data: bus.alu_data};

    if (deq) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      write_addr_d = mem_q[rd_ptr_q].addr;
      write_data_d = mem_q[rd_ptr_q].data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity comes from
  // count/rd_ptr, so stale contents are never observed and the array can map
  // onto plain flops or a small RAM without reset wiring.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Forwarding and scoreboard. Output stage is the oldest candidate, then queue
  // entries oldest->newest; later matches overwrite earlier ones, so the newest
  // value wins.
  logic              hit1, hit2;
  logic [DATA_W-1:0] fdata1, fdata2;
  logic [NR-1:0]     pend;
  logic [PW-1:0]     idx;

  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    fdata1 = '0;
    fdata2 = '0;
    pend   = '0;
    idx    = '0;

    if (write_en_q && (write_addr_q == bus.readAddr1)) begin
      hit1   = 1'b1;
      fdata1 = write_data_q;
    end
    if (write_en_q && (write_addr_q == bus.readAddr2)) begin
      hit2   = 1'b1;
      fdata2 = write_data_q;
    end

    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        pend[mem_q[idx].addr] = 1'b1;
        if (mem_q[idx].addr == bus.readAddr1) begin
          hit1   = 1'b1;
          fdata1 = mem_q[idx].data;
        end
        if (mem_q[idx].addr == bus.readAddr2) begin
          hit2   = 1'b1;
          fdata2 = mem_q[idx].data;
        end
      end
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.writeEn   = write_en_q;
  assign bus.writeAddr = write_addr_q;
  assign bus.writeData = write_data_q;
  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_data1 = fdata1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data2 = fdata2;
  assign bus.pending   = pend;
  assign bus.count     = count_q;
endmodule
